// File: rtl/cam_capture_pkg.sv
// Shared encodings for the OV7670 capture slice: pixel formats and capture FSM states.
package cam_capture_pkg;

    typedef enum logic [1:0] {
        MODE_RGB565   = 2'd0,
        MODE_YUV_Y    = 2'd1,
        MODE_RGB444   = 2'd2,
        MODE_RESERVED = 2'd3
    } cam_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC_HI = 3'd1,
        ST_SYNC_LO = 3'd2,
        ST_ACTIVE  = 3'd3,
        ST_DONE    = 3'd4
    } cam_state_e;

endpackage

// File: rtl/cam_frame_capture_if.sv
// Camera pixel bus in, frame-buffer BRAM write port out.
interface cam_frame_capture_if #(
    parameter int ADDR_W = 19
);
    logic              vsync;
    logic              href;
    logic [7:0]        d;
    logic [ADDR_W-1:0] addr;
    logic [11:0]       dout;
    logic              we;

    modport master (output vsync, output href, output d, input addr, input dout, input we);
    modport slave  (input vsync, input href, input d, output addr, output dout, output we);
endinterface

// File: rtl/cam_pixel_pack.sv
// Combinational byte-pair to RGB444 packer; reserved mode 3 behaves as RGB565.
module cam_pixel_pack
    import cam_capture_pkg::*;
(
    input  logic [1:0]  mode,
    input  logic [7:0]  b0,
    input  logic [7:0]  b1,
    output logic [11:0] pix
);

    // Select the nibble extraction for the current camera format.
    always_comb begin
        pix = 12'h000;
        case (mode)
            MODE_YUV_Y:  pix = {b0[7:4], b0[7:4], b0[7:4]};
            MODE_RGB444: pix = {b0[3:0], b1[7:4], b1[3:0]};
            default:     pix = {b0[7:4], b0[2:0], b1[7], b1[4:1]};
        endcase
    end

endmodule

// File: rtl/cam_frame_capture.sv
// OV7670 capture engine: byte pairing, H/V decimation, window clipping and BRAM write generation.
module cam_frame_capture
    import cam_capture_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int DECIM_H  = 1,
    parameter int DECIM_V  = 1,
    parameter int ADDR_W   = 19
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               arm,
    input  logic               cont,
    input  logic [1:0]         mode,
    cam_frame_capture_if.slave bus,
    output logic               frame_done,
    output logic               busy,
    output logic               clipped,
    output logic               sync_err,
    output logic [7:0]         frame_cnt
);

    localparam int CW  = $clog2(H_ACTIVE + 1);
    localparam int RW  = $clog2(V_ACTIVE + 1);
    localparam int HPW = (DECIM_H > 1) ? $clog2(DECIM_H) : 1;
    localparam int VPW = (DECIM_V > 1) ? $clog2(DECIM_V) : 1;

    localparam logic [2:0] S_IDLE    = ST_IDLE;
    localparam logic [2:0] S_SYNC_HI = ST_SYNC_HI;
    localparam logic [2:0] S_SYNC_LO = ST_SYNC_LO;
    localparam logic [2:0] S_ACTIVE  = ST_ACTIVE;
    localparam logic [2:0] S_DONE    = ST_DONE;

    logic              vsync_r, href_r, vsync_q, href_q, phase_r;
    logic [7:0]        d_r, b0_r;
    logic [2:0]        state_r, state_nxt_s;
    logic [HPW-1:0]    hphase_r;
    logic [VPW-1:0]    vphase_r;
    logic [CW-1:0]     col_r;
    logic [RW-1:0]     row_r;
    logic [ADDR_W-1:0] line_base_r, pend_addr_r, addr_r;
    logic              line_px_r, pend_we_r, we_r;
    logic [11:0]       pend_pix_r, dout_r, pix_s;
    logic              frame_done_r, busy_r, clipped_r, sync_err_r;
    logic [7:0]        frame_cnt_r;

    logic vs_rise_s, vs_fall_s, hr_rise_s, hr_fall_s;
    logic start_s, active_s, px_done_s, keep_s, in_win_s;

    assign vs_rise_s = vsync_r & ~vsync_q;
    assign vs_fall_s = ~vsync_r & vsync_q;
    assign hr_rise_s = href_r & ~href_q;
    assign hr_fall_s = ~href_r & href_q;
    assign start_s   = (state_r == S_SYNC_LO) & vs_fall_s;
    assign active_s  = (state_r == S_ACTIVE);
    assign px_done_s = active_s & href_r & phase_r;
    assign keep_s    = px_done_s & (hphase_r == HPW'(0)) & (vphase_r == VPW'(0));
    assign in_win_s  = (col_r < CW'(H_ACTIVE)) & (row_r < RW'(V_ACTIVE));

    cam_pixel_pack u_pack (
        .mode (mode),
        .b0   (b0_r),
        .b1   (d_r),
        .pix  (pix_s)
    );

    // Next-state logic of the framing FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE:    if (arm)       state_nxt_s = S_SYNC_HI; else state_nxt_s = S_IDLE;
            S_SYNC_HI: if (vsync_r)   state_nxt_s = S_SYNC_LO; else state_nxt_s = S_SYNC_HI;
            S_SYNC_LO: if (vs_fall_s) state_nxt_s = S_ACTIVE;  else state_nxt_s = S_SYNC_LO;
            S_ACTIVE:  if (vs_rise_s) state_nxt_s = S_DONE;    else state_nxt_s = S_ACTIVE;
            S_DONE:    if (cont)      state_nxt_s = S_SYNC_LO; else state_nxt_s = S_IDLE;
            default:   state_nxt_s = S_IDLE;
        endcase
    end

    // Input register stage, edge history and byte phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vsync_r <= 1'b0; href_r <= 1'b0; d_r <= 8'h00;
            vsync_q <= 1'b0; href_q <= 1'b0;
            phase_r <= 1'b0; b0_r <= 8'h00;
        end else begin
            vsync_r <= bus.vsync;
            href_r  <= bus.href;
            d_r     <= bus.d;
            vsync_q <= vsync_r;
            href_q  <= href_r;
            phase_r <= href_r ? ~phase_r : 1'b0;
            if (href_r && !phase_r) b0_r <= d_r;
        end
    end

    // FSM state and frame-level status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IDLE; busy_r <= 1'b0; frame_done_r <= 1'b0;
            frame_cnt_r <= 8'd0; clipped_r <= 1'b0; sync_err_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            busy_r       <= (state_nxt_s != S_IDLE);
            frame_done_r <= (state_nxt_s == S_DONE);
            if (state_nxt_s == S_DONE) frame_cnt_r <= frame_cnt_r + 8'd1;
            if (start_s) begin
                clipped_r  <= 1'b0;
                sync_err_r <= 1'b0;
            end else begin
                if (keep_s && !in_win_s) clipped_r <= 1'b1;
                if (active_s && hr_fall_s && phase_r) sync_err_r <= 1'b1;
            end
        end
    end

    // Decimation phases and output column/row tracking; col/row saturate at the window edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hphase_r <= '0; vphase_r <= '0; col_r <= '0; row_r <= '0;
            line_base_r <= '0; line_px_r <= 1'b0;
        end else if (start_s) begin
            hphase_r <= '0; vphase_r <= '0; col_r <= '0; row_r <= '0;
            line_base_r <= '0; line_px_r <= 1'b0;
        end else if (active_s) begin
            if (hr_rise_s) begin
                hphase_r  <= '0;
                col_r     <= '0;
                line_px_r <= 1'b0;
            end else if (px_done_s) begin
                hphase_r <= (hphase_r == HPW'(DECIM_H - 1)) ? '0 : hphase_r + HPW'(1);
                if (keep_s) begin
                    line_px_r <= 1'b1;
                    if (col_r < CW'(H_ACTIVE)) col_r <= col_r + CW'(1);
                end
            end else if (hr_fall_s) begin
                vphase_r <= (vphase_r == VPW'(DECIM_V - 1)) ? '0 : vphase_r + VPW'(1);
                // Lines that produced no pixel do not consume a frame-buffer row.
                if (line_px_r && (row_r < RW'(V_ACTIVE))) begin
                    row_r       <= row_r + RW'(1);
                    line_base_r <= line_base_r + ADDR_W'(H_ACTIVE);
                end
            end
        end
    end

    // Two-stage write pipeline: pack/address, then the registered BRAM port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_we_r <= 1'b0; pend_addr_r <= '0; pend_pix_r <= 12'h000;
            we_r <= 1'b0; addr_r <= '0; dout_r <= 12'h000;
        end else begin
            pend_we_r <= keep_s & in_win_s;
            if (keep_s) begin
                pend_addr_r <= line_base_r + ADDR_W'(col_r);
                pend_pix_r  <= pix_s;
            end
            we_r <= pend_we_r;
            if (pend_we_r) begin
                addr_r <= pend_addr_r;
                dout_r <= pend_pix_r;
            end
        end
    end

    assign bus.we     = we_r;
    assign bus.addr   = addr_r;
    assign bus.dout   = dout_r;
    assign frame_done = frame_done_r;
    assign busy       = busy_r;
    assign clipped    = clipped_r;
    assign sync_err   = sync_err_r;
    assign frame_cnt  = frame_cnt_r;

endmodule

// File: tb/tb_cam_frame_capture.sv
// Drives two capture engines (no decimation / 2x2 decimation) with the same camera stream
// and compares their BRAM writes and status against a line/pixel-level reference model.
module tb_cam_frame_capture;

    localparam int HA = 4;
    localparam int VA = 2;
    localparam int AW = 3;

    logic       clk = 1'b0;
    logic       reset_n, arm, cont, vsync, href;
    logic [1:0] mode;
    logic [7:0] d;
    logic       fd_a, busy_a, clip_a, serr_a, fd_b, busy_b, clip_b, serr_b;
    logic [7:0] fcnt_a, fcnt_b;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;
    int exp_fcnt = 0;
    int fdn_a = 0;
    int fdn_b = 0;
    int got_a[$];
    int got_b[$];
    int exp_a[$];
    int exp_b[$];

    int         n_lines;
    int         llen[8];
    logic [7:0] lbyte[8][24];

    always #5 clk = ~clk;

    cam_frame_capture_if #(.ADDR_W(AW)) bus_a ();
    cam_frame_capture_if #(.ADDR_W(AW)) bus_b ();

    assign bus_a.vsync = vsync;
    assign bus_a.href  = href;
    assign bus_a.d     = d;
    assign bus_b.vsync = vsync;
    assign bus_b.href  = href;
    assign bus_b.d     = d;

    cam_frame_capture #(.H_ACTIVE(HA), .V_ACTIVE(VA), .DECIM_H(1), .DECIM_V(1), .ADDR_W(AW)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .arm(arm), .cont(cont), .mode(mode), .bus(bus_a),
        .frame_done(fd_a), .busy(busy_a), .clipped(clip_a), .sync_err(serr_a), .frame_cnt(fcnt_a));

    cam_frame_capture #(.H_ACTIVE(HA), .V_ACTIVE(VA), .DECIM_H(2), .DECIM_V(2), .ADDR_W(AW)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .arm(arm), .cont(cont), .mode(mode), .bus(bus_b),
        .frame_done(fd_b), .busy(busy_b), .clipped(clip_b), .sync_err(serr_b), .frame_cnt(fcnt_b));

    // Write and frame_done monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus_a.we === 1'b1) got_a.push_back(int'({17'd0, bus_a.addr, bus_a.dout}));
        if (bus_b.we === 1'b1) got_b.push_back(int'({17'd0, bus_b.addr, bus_b.dout}));
        if (fd_a === 1'b1) fdn_a++;
        if (fd_b === 1'b1) fdn_b++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] ref_pix(input int md, input logic [7:0] b0, input logic [7:0] b1);
        int r, g, b;
        case (md)
            1: begin r = b0 / 16; g = r; b = r; end
            2: begin r = b0 % 16; g = b1 / 16; b = b1 % 16; end
            default: begin r = b0 / 16; g = (b0 % 8) * 2 + b1 / 128; b = (b1 / 2) % 16; end
        endcase
        return 12'(r * 256 + g * 16 + b);
    endfunction

    // Expected writes for instance k (0: 1x1 decimation, 1: 2x2) from the current line table.
    task automatic build_exp(input int k, input int md, output logic clip, output logic serr);
        int dh, dv, row, np, c, v;
        dh = (k == 0) ? 1 : 2;
        dv = dh;
        row = 0; clip = 1'b0; serr = 1'b0;
        for (int l = 0; l < n_lines; l++) begin
            np = llen[l] / 2;
            if (llen[l] % 2 == 1) serr = 1'b1;
            if ((l % dv == 0) && (np > 0)) begin
                for (int p = 0; p < np; p++) begin
                    if (p % dh == 0) begin
                        c = p / dh;
                        if (c < HA && row < VA) begin
                            v = (row * HA + c) * 4096 + int'(ref_pix(md, lbyte[l][2*p], lbyte[l][2*p+1]));
                            if (k == 0) exp_a.push_back(v); else exp_b.push_back(v);
                        end else begin
                            clip = 1'b1;
                        end
                    end
                end
                row++;
            end
        end
    endtask

    task automatic check_frame(input string tag, input int md);
        logic ca, sa, cb, sb;
        exp_a.delete();
        exp_b.delete();
        build_exp(0, md, ca, sa);
        build_exp(1, md, cb, sb);
        chk({tag, "_nwr_a"}, got_a.size(), exp_a.size());
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) chk({tag, "_wr_a"}, got_a[i], exp_a[i]);
        chk({tag, "_nwr_b"}, got_b.size(), exp_b.size());
        for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) chk({tag, "_wr_b"}, got_b[i], exp_b[i]);
        chk({tag, "_clip_a"}, clip_a, ca);
        chk({tag, "_serr_a"}, serr_a, sa);
        chk({tag, "_clip_b"}, clip_b, cb);
        chk({tag, "_serr_b"}, serr_b, sb);
        exp_fcnt++;
        chk({tag, "_fcnt_a"}, fcnt_a, exp_fcnt % 256);
        chk({tag, "_fcnt_b"}, fcnt_b, exp_fcnt % 256);
        chk({tag, "_fdone_a"}, fdn_a, exp_fcnt);
        chk({tag, "_fdone_b"}, fdn_b, exp_fcnt);
        got_a.delete();
        got_b.delete();
    endtask

    task automatic set_const_frame(input int nl, input int nb, input logic [7:0] b0, input logic [7:0] b1);
        n_lines = nl;
        for (int l = 0; l < nl; l++) begin
            llen[l] = nb;
            for (int b = 0; b < nb; b++) lbyte[l][b] = (b % 2 == 0) ? b0 : b1;
        end
    endtask

    task automatic set_rand_frame(input int nl, input int maxlen);
        n_lines = nl;
        for (int l = 0; l < nl; l++) begin
            llen[l] = $urandom_range(1, maxlen);
            for (int b = 0; b < llen[l]; b++) lbyte[l][b] = 8'($urandom);
        end
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    // One camera frame from the line table; arm is pulsed on the first byte of line arm_line.
    task automatic run_frame(input int arm_line);
        vsync = 1'b1;
        repeat (4) @(negedge clk);
        vsync = 1'b0;
        repeat (3) @(negedge clk);
        for (int l = 0; l < n_lines; l++) begin
            href = 1'b1;
            for (int b = 0; b < llen[l]; b++) begin
                d   = lbyte[l][b];
                arm = (l == arm_line && b == 0);
                @(negedge clk);
            end
            href = 1'b0;
            d    = 8'h00;
            arm  = 1'b0;
            repeat (4) @(negedge clk);
        end
        vsync = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0; arm = 1'b0; cont = 1'b0; mode = 2'd0;
        vsync = 1'b0; href = 1'b0; d = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_we", bus_a.we, 32'd0);
        chk("rst_addr", bus_a.addr, 32'd0);
        chk("rst_dout", bus_a.dout, 32'd0);
        chk("rst_busy", busy_a, 32'd0);
        chk("rst_fdone", fd_a, 32'd0);
        chk("rst_fcnt", fcnt_a, 32'd0);
        chk("rst_flags", {clip_a, serr_a}, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reset asserted mid-line aborts the capture.
        pulse_arm();
        vsync = 1'b1; repeat (4) @(negedge clk);
        vsync = 1'b0; repeat (3) @(negedge clk);
        href = 1'b1; d = 8'hF8; @(negedge clk);
        d = 8'h1F; @(negedge clk);
        reset_n = 1'b0; d = 8'hF8;
        repeat (2) @(negedge clk);
        chk("mr_we", bus_a.we, 32'd0);
        chk("mr_addr", bus_a.addr, 32'd0);
        chk("mr_fcnt", fcnt_a, 32'd0);
        chk("mr_busy", busy_a, 32'd0);
        got_a.delete();
        got_b.delete();
        d = 8'h1F; @(negedge clk);
        reset_n = 1'b1; d = 8'hF8; @(negedge clk);
        d = 8'h1F; @(negedge clk);
        href = 1'b0; repeat (4) @(negedge clk);
        vsync = 1'b1; repeat (6) @(negedge clk);
        chk("mr_nowr_a", got_a.size(), 32'd0);
        chk("mr_nowr_b", got_b.size(), 32'd0);
        chk("mr_idle", busy_a, 32'd0);

        // RGB565 constant frame.
        mode = 2'd0;
        set_const_frame(2, 8, 8'hF8, 8'h1F);
        pulse_arm();
        run_frame(-1);
        chk("t2_nwr", got_a.size(), 32'd8);
        chk("t2_w0", (got_a.size() > 0) ? got_a[0] : -1, 32'h0F0F);
        chk("t2_w7", (got_a.size() > 7) ? got_a[7] : -1, 32'h7F0F);
        check_frame("t2", 0);
        chk("t2_busy", busy_a, 32'd0);

        // 8x4 frame in native RGB444: 2x2 decimation keeps even columns of rows 0 and 2.
        mode = 2'd2;
        set_rand_frame(4, 2);
        for (int l = 0; l < 4; l++) begin
            llen[l] = 16;
            for (int b = 0; b < 16; b++) lbyte[l][b] = 8'($urandom);
        end
        pulse_arm();
        run_frame(-1);
        chk("t3_nwr_b", got_b.size(), 32'd8);
        chk("t3_clip_a", clip_a, 32'd1);
        check_frame("t3", 2);

        // Odd-length grey line followed by normal lines.
        mode = 2'd1;
        set_rand_frame(3, 8);
        llen[0] = 7;
        for (int b = 0; b < 7; b++) lbyte[0][b] = 8'hA5;
        llen[1] = 8;
        llen[2] = 8;
        pulse_arm();
        run_frame(-1);
        chk("t5_w0", (got_a.size() > 0) ? got_a[0] : -1, 32'h0AAA);
        chk("t5_serr", serr_a, 32'd1);
        check_frame("t5", 1);

        // Continuous capture: over-long lines, then a short frame that clears clipped, then random frames.
        cont = 1'b1;
        mode = 2'd0;
        set_const_frame(2, 20, 8'h3C, 8'hC3);
        pulse_arm();
        run_frame(-1);
        chk("c0_clip_b", clip_b, 32'd1);
        check_frame("c0", 0);
        mode = 2'd3;
        set_rand_frame(2, 4);
        llen[0] = 4;
        llen[1] = 4;
        run_frame(-1);
        chk("c1_clip_a", clip_a, 32'd0);
        check_frame("c1", 3);
        for (int f = 0; f < 4; f++) begin
            mode = 2'($urandom_range(0, 3));
            set_rand_frame($urandom_range(1, 5), 12);
            if (f == 3) cont = 1'b0;
            run_frame(-1);
            check_frame("rnd", int'(mode));
        end
        chk("rnd_idle", busy_a, 32'd0);

        // Single-shot: arm mid-frame waits for the next full frame, then the engine stops.
        mode = 2'($urandom_range(0, 3));
        set_rand_frame(3, 10);
        run_frame(1);
        chk("t6_nowr_a", got_a.size(), 32'd0);
        chk("t6_nowr_b", got_b.size(), 32'd0);
        chk("t6_armed", busy_a, 32'd1);
        set_rand_frame(4, 10);
        run_frame(-1);
        check_frame("t6", int'(mode));
        chk("t6_busy", busy_a, 32'd0);
        run_frame(-1);
        chk("t6_third_a", got_a.size(), 32'd0);
        chk("t6_third_b", got_b.size(), 32'd0);
        chk("t6_fcnt", fcnt_a, exp_fcnt % 256);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
